// File: rtl/operand_fetch_if.sv
// Bundle of decode-side inputs, write-back port, stall and ALU-side outputs of the operand fetch stage.
// The master drives the instruction, write-back and stall signals; the slave returns the ready flag and the captured operands.
interface operand_fetch_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] out1address;
   logic [2:0] out2address;
   logic [7:0] immediate;
   logic       imm_sel;
   logic       neg_sel;
   logic [3:0] aluop;
   logic [2:0] dest;
   logic       wb_en;
   logic [2:0] wb_address;
   logic [7:0] wb_data;
   logic       stall;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [3:0] select;
   logic       out_valid;
   logic [2:0] out_dest;

   modport master (
      output in_valid, out1address, out2address, immediate, imm_sel, neg_sel,
             aluop, dest, wb_en, wb_address, wb_data, stall,
      input  in_ready, data1, data2, select, out_valid, out_dest
   );

   modport slave (
      input  in_valid, out1address, out2address, immediate, imm_sel, neg_sel,
             aluop, dest, wb_en, wb_address, wb_data, stall,
      output in_ready, data1, data2, select, out_valid, out_dest
   );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: 8x8 register file with write-back bypass, an immediate/negate mux on operand 2,
// and a single stallable output register that feeds the ALU.
module operand_fetch (
   input  logic              clk,
   input  logic              reset_n,
   operand_fetch_if.slave    bus
);
   logic [7:0] rf_q [8];
   logic [7:0] rd1;
   logic [7:0] rd2;
   logic [7:0] op2_src;
   logic [7:0] op2;
   logic       accept;

   logic [7:0] data1_reg;
   logic [7:0] data2_reg;
   logic [3:0] select_reg;
   logic [2:0] out_dest_reg;
   logic       out_valid_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_rf
         logic [7:0] value_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               value_reg <= 8'h00;
            end else if (bus.wb_en && (bus.wb_address == 3'(gi))) begin
               value_reg <= bus.wb_data;
            end
         end

         assign rf_q[gi] = value_reg;
      end
   endgenerate

   // A write-back landing on the same edge as the read must be visible to the instruction being accepted.
   always_comb begin
      rd1 = rf_q[bus.out1address];
      rd2 = rf_q[bus.out2address];
      if (bus.wb_en && (bus.wb_address == bus.out1address)) begin
         rd1 = bus.wb_data;
      end
      if (bus.wb_en && (bus.wb_address == bus.out2address)) begin
         rd2 = bus.wb_data;
      end
   end

   always_comb begin
      op2_src = bus.imm_sel ? bus.immediate : rd2;
      op2     = bus.neg_sel ? (~op2_src + 8'd1) : op2_src;
   end

   assign bus.in_ready = !out_valid_reg || !bus.stall;
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data1_reg     <= 8'h00;
         data2_reg     <= 8'h00;
         select_reg    <= 4'h0;
         out_dest_reg  <= 3'h0;
         out_valid_reg <= 1'b0;
      end else if (accept) begin
         data1_reg     <= rd1;
         data2_reg     <= op2;
         select_reg    <= bus.aluop;
         out_dest_reg  <= bus.dest;
         out_valid_reg <= 1'b1;
      end else if (!bus.stall) begin
         // Drained with nothing behind it: drop valid, keep the data as last seen.
         out_valid_reg <= 1'b0;
      end
   end

   assign bus.data1     = data1_reg;
   assign bus.data2     = data2_reg;
   assign bus.select    = select_reg;
   assign bus.out_dest  = out_dest_reg;
   assign bus.out_valid = out_valid_reg;
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports SHALL be as listed in REQ-002 to REQ-020.
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 IN_VALID  in  1  decoded instruction present this cycle.
REQ-005 IN_READY  out  1  stage accepts the instruction this cycle.
REQ-006 OUT1ADDRESS  in  3  register index for DATA1.
REQ-007 OUT2ADDRESS  in  3  register index for DATA2.
REQ-008 IMMEDIATE  in  8  immediate operand.
REQ-009 IMM_SEL  in  1  1: DATA2 source is IMMEDIATE; 0: register OUT2ADDRESS.
REQ-010 NEG_SEL  in  1  1: DATA2 is the two's complement of the selected source.
REQ-011 ALUOP  in  4  ALU select code, passed through unchanged.
REQ-012 DEST  in  3  destination register index, passed through.
REQ-013 WB_EN  in  1  write-back enable.
REQ-014 WB_ADDRESS  in  3  write-back register index.
REQ-015 WB_DATA  in  8  write-back value (ALU RESULT).
REQ-016 STALL  in  1  downstream cannot consume the output this cycle.
REQ-017 DATA1  out  8  registered operand 1 to the ALU.
REQ-018 DATA2  out  8  registered operand 2 to the ALU.
REQ-019 SELECT  out  4  registered ALU select.
REQ-020 OUT_VALID / OUT_DEST  out  1 / 3  output-register valid flag and destination index.

Function
REQ-021 Storage SHALL be 8 registers of 8 bits; register 0 SHALL be writable like any other.
REQ-022 On a rising CLK with WB_EN=1, register[WB_ADDRESS] SHALL be written with WB_DATA.
REQ-023 Register reads SHALL be combinational, with bypass: if WB_EN=1 and WB_ADDRESS matches a read address in the same cycle, that read SHALL return WB_DATA.
REQ-024 Both read ports SHALL be allowed to address the same register in the same cycle.
REQ-025 Operand 2 SHALL be muxed first: IMMEDIATE if IMM_SEL=1, else the register value. Negation SHALL be applied after the mux when NEG_SEL=1: (~x+1) mod 256.
REQ-026 Negation SHALL map 0x00 to 0x00 and 0x80 to 0x80, with no overflow flag.
REQ-027 IN_READY SHALL equal (!OUT_VALID || !STALL), combinationally.
REQ-028 Accept = IN_VALID && IN_READY. On the accepting edge, DATA1, DATA2, SELECT and OUT_DEST SHALL load from the current-cycle values, and OUT_VALID SHALL be set to 1.
REQ-029 Latency from accept to OUT_VALID=1 SHALL be 1 cycle.
REQ-030 If OUT_VALID=1, STALL=0 and there is no accept, OUT_VALID SHALL clear on the next edge. The data outputs SHALL hold their last values.
REQ-031 While OUT_VALID=1 and STALL=1, all outputs SHALL hold. A write-back during the stall SHALL NOT alter the captured operands.
REQ-032 Accept and drain in the same cycle SHALL replace the output register with no bubble (full throughput).
REQ-033 A write-back SHALL proceed regardless of IN_VALID, STALL or IN_READY.
REQ-034 A write-back and an accept reading the same register on the same edge SHALL capture WB_DATA (per REQ-023).

Reset
REQ-035 RESET_N=0 SHALL immediately, without a clock, clear all 8 registers to 0x00.
REQ-036 RESET_N=0 SHALL immediately clear DATA1, DATA2, SELECT, OUT_DEST and OUT_VALID to 0.
REQ-037 While RESET_N=0, WB_EN and IN_VALID SHALL be ignored. IN_READY SHALL read 1 (OUT_VALID=0).
REQ-038 Reset asserted mid-stall SHALL discard the held instruction. The first edge with RESET_N=1 SHALL operate normally.

Verification
REQ-039 Reset: write 0x5A to r3, pulse RESET_N low between edges -> r3 reads 0x00 and OUT_VALID=0 before the next edge.
REQ-040 Bypass: WB_EN=1, WB_ADDRESS=2, WB_DATA=0x11, and accept with OUT1ADDRESS=2 on the same edge -> DATA1=0x11 and OUT_VALID=1 one cycle later.
REQ-041 Immediate/negate: IMM_SEL=1, IMMEDIATE=0x05, NEG_SEL=1, ALUOP=0001 -> DATA2=0xFB, SELECT=0001. Repeat with IMMEDIATE=0x80 -> DATA2=0x80. Repeat with IMMEDIATE=0x00 -> DATA2=0x00.
REQ-042 Stall hold: accept instruction A, then STALL=1 for 3 cycles with WB_EN writing A's source register -> outputs hold A's originally captured values; IN_READY=0 during the stall; next instruction accepted on the first edge with STALL=0.
REQ-043 Throughput: IN_VALID=1 and STALL=0 for 8 consecutive cycles -> 8 consecutive OUT_VALID=1 cycles in order, then OUT_VALID=0 one cycle after IN_VALID falls.
REQ-044 Reset mid-stall: OUT_VALID=1, STALL=1, assert RESET_N=0 -> OUT_VALID=0 and DATA1/DATA2=0x00 asynchronously; WB_EN pulses during reset leave all registers 0x00.
